sha3_squeeze_axis: RTL and testbench

//  Digest/XOF output stage for the SHA3 core. Latches the 5x5x64 Keccak state after the final permutation.

---
 rtl/sha3_pkg.sv | 52 +++++
 rtl/sha3_beat_mux.sv | 27 ++
 rtl/sha3_squeeze_axis.sv | 148 ++++++++++++++
 tb/tb_sha3_squeeze_axis.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and mode tables for the SHA3 squeeze/output stage.
package sha3_pkg;

  typedef enum logic [2:0] {
    SHA3_224 = 3'd0,
    SHA3_256 = 3'd1,
    SHA3_384 = 3'd2,
    SHA3_512 = 3'd3,
    SHAKE128 = 3'd4,
    SHAKE256 = 3'd5
  } sha3_mode_e;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0][4:0] state_t;

  // Unused TUSER codes fall back to SHA3-256.
  function automatic sha3_mode_e decode_mode(input logic [2:0] tuser);
    case (tuser)
      3'd0:    return SHA3_224;
      3'd2:    return SHA3_384;
      3'd3:    return SHA3_512;
      3'd4:    return SHAKE128;
      3'd5:    return SHAKE256;
      default: return SHA3_256;
    endcase
  endfunction

  function automatic logic [7:0] rate_bytes(input sha3_mode_e mode);
    case (mode)
      SHA3_224: return 8'd144;
      SHA3_384: return 8'd104;
      SHA3_512: return 8'd72;
      SHAKE128: return 8'd168;
      default:  return 8'd136;
    endcase
  endfunction

  function automatic logic [7:0] digest_bytes(input sha3_mode_e mode);
    case (mode)
      SHA3_224: return 8'd28;
      SHA3_256: return 8'd32;
      SHA3_384: return 8'd48;
      SHA3_512: return 8'd64;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic is_shake(input sha3_mode_e mode);
    return (mode == SHAKE128) || (mode == SHAKE256);
  endfunction

endpackage

// File: rtl/sha3_beat_mux.sv
// Picks the DATA_WIDTH-bit slice for one output beat out of the held Keccak state.
module sha3_beat_mux
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  state_t                  state_i,
  input  logic [7:0]              beat_idx_i,
  output logic [DATA_WIDTH-1:0]   data_o
);

  logic [1599:0] flat;
  logic [10:0]   base;

  // State byte order walks x fastest, then y, so lane (x,y) sits at 64*(5y+x).
  always_comb begin
    flat = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        flat[(5*y + x)*64 +: 64] = state_i[x][y];
      end
    end
    base   = 11'(beat_idx_i) * 11'(DATA_WIDTH);
    data_o = flat[base +: DATA_WIDTH];
  end

endmodule

// File: rtl/sha3_squeeze_axis.sv
// SHA3/SHAKE digest output stage: holds the final state and streams it over AXI-Stream.
// Define SHA3_OUT_TKEEP_EN to add the M_TKEEP byte-enable port.
module sha3_squeeze_axis
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  state_t                  Din,
  input  logic                    Din_valid,
  output logic                    Din_ready,
  input  logic [2:0]              TUSER,
  input  logic [LEN_W-1:0]        out_len,
  output logic                    perm_req,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic                    M_TLAST,
`ifdef SHA3_OUT_TKEEP_EN
  output logic [DATA_WIDTH/8-1:0] M_TKEEP,
`endif
  output logic                    Done
);

  localparam int B = DATA_WIDTH / 8;
  localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(B);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_STREAM    = 2'd1;
  localparam logic [1:0] ST_WAIT_PERM = 2'd2;

  logic [1:0]       state_q, state_d;
  state_t           held_q, held_d;
  sha3_mode_e       mode_q, mode_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       beat_idx_q, beat_idx_d;
  logic             din_ready_q, din_ready_d;
  logic             done_q, done_d;
  logic             perm_req_q, perm_req_d;

  logic             accept, handshake, final_beat, last_of_block;
  logic [7:0]       block_last_idx;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [B-1:0]     byte_keep;

  assign accept         = Din_valid && din_ready_q;
  assign M_TVALID       = (state_q == ST_STREAM);
  assign handshake      = M_TVALID && M_TREADY;
  assign final_beat     = (remaining_q <= BEAT_BYTES);
  assign block_last_idx = rate_bytes(mode_q) / 8'(B) - 8'd1;
  assign last_of_block  = (beat_idx_q == block_last_idx);

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    beat_idx_d  = beat_idx_q;
    done_d      = 1'b0;
    perm_req_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          held_d      = Din;
          mode_d      = decode_mode(TUSER);
          remaining_d = is_shake(mode_d) ? out_len : LEN_W'(digest_bytes(mode_d));
          beat_idx_d  = 8'd0;
          // A zero-length XOF completes without ever raising TVALID.
          if (remaining_d == '0) done_d = 1'b1;
          else                   state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (handshake) begin
          remaining_d = final_beat ? '0 : remaining_q - BEAT_BYTES;
          beat_idx_d  = beat_idx_q + 8'd1;
          if (final_beat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (last_of_block) begin
            perm_req_d = 1'b1;
            state_d    = ST_WAIT_PERM;
          end
        end
      end
      ST_WAIT_PERM: begin
        if (accept) begin
          held_d     = Din;
          beat_idx_d = 8'd0;
          state_d    = ST_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    din_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_PERM);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      mode_q      <= SHA3_224;
      remaining_q <= '0;
      beat_idx_q  <= 8'd0;
      din_ready_q <= 1'b0;
      done_q      <= 1'b0;
      perm_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      beat_idx_q  <= beat_idx_d;
      din_ready_q <= din_ready_d;
      done_q      <= done_d;
      perm_req_q  <= perm_req_d;
    end
  end

  // The held state is pure data and never observed outside STREAM, so it skips reset.
  always_ff @(posedge ACLK) begin
    held_q <= held_d;
  end

  sha3_beat_mux #(.DATA_WIDTH(DATA_WIDTH)) u_beat_mux (
    .state_i    (held_q),
    .beat_idx_i (beat_idx_q),
    .data_o     (beat_data)
  );

  always_comb begin
    M_TDATA = '0;
    for (int i = 0; i < B; i++) begin
      byte_keep[i]       = M_TVALID && (!final_beat || (LEN_W'(i) < remaining_q));
      M_TDATA[8*i +: 8]  = byte_keep[i] ? beat_data[8*i +: 8] : 8'h00;
    end
  end

  assign M_TLAST   = M_TVALID && final_beat;
  assign Din_ready = din_ready_q;
  assign perm_req  = perm_req_q;
  assign Done      = done_q;

`ifdef SHA3_OUT_TKEEP_EN
  assign M_TKEEP = byte_keep;
`endif

endmodule

// File: tb/tb_sha3_squeeze_axis.sv
// Self-checking bench for sha3_squeeze_axis at DATA_WIDTH=16: vector table plus reset corner case.
module tb_sha3_squeeze_axis;
  import sha3_pkg::*;

  localparam int DW = 16;
  localparam int B  = DW / 8;

  logic            ACLK = 1'b0;
  logic            ARESET;
  state_t          Din;
  logic            Din_valid;
  logic            Din_ready;
  logic [2:0]      TUSER;
  logic [15:0]     out_len;
  logic            perm_req;
  logic [DW-1:0]   M_TDATA;
  logic            M_TVALID;
  logic            M_TREADY;
  logic            M_TLAST;
`ifdef SHA3_OUT_TKEEP_EN
  logic [B-1:0]    M_TKEEP;
`endif
  logic            Done;

  int     checks = 0;
  int     errors = 0;
  state_t st;
  int     seed = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] len;
    bit          rnd;
    int          exp_bytes;
    int          exp_perms;
  } vec_t;

  vec_t vecs[12];

  sha3_squeeze_axis #(.DATA_WIDTH(DW), .LEN_W(16)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .Din       (Din),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .TUSER     (TUSER),
    .out_len   (out_len),
    .perm_req  (perm_req),
    .M_TDATA   (M_TDATA),
    .M_TVALID  (M_TVALID),
    .M_TREADY  (M_TREADY),
    .M_TLAST   (M_TLAST),
`ifdef SHA3_OUT_TKEEP_EN
    .M_TKEEP   (M_TKEEP),
`endif
    .Done      (Done)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte n of the state lives in lane x=(n/8)%5, y=(n/8)/5.
  function automatic logic [7:0] model_byte(input state_t s, input int n);
    int l;
    l = n / 8;
    return s[l % 5][l / 5][8*(n % 8) +: 8];
  endfunction

  task automatic fill_state();
    int l;
    for (int n = 0; n < 200; n++) begin
      l = n / 8;
      st[l % 5][l / 5][8*(n % 8) +: 8] = 8'(n*13 + seed*29 + 1);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] mode, input logic [15:0] len);
    int n;
    n = 0;
    while (!Din_ready && n < 20) begin
      step();
      n++;
    end
    check_output("din_ready_wait", Din_ready, 1);
    seed++;
    fill_state();
    Din       = st;
    Din_valid = 1'b1;
    TUSER     = mode;
    out_len   = len;
  endtask

  task automatic run_stream(input vec_t v, input string tag);
    int emitted, blk, beats, perms, early_done, exp_beats;
    bit stall, fin_hs, got_done;
    logic [16:0]   prev;
    logic [DW-1:0] expw;
    apply_stimulus(v.mode, v.len);
    M_TREADY   = 1'b1;
    emitted    = 0;
    blk        = 0;
    beats      = 0;
    perms      = 0;
    early_done = 0;
    stall      = 1'b0;
    got_done   = 1'b0;
    prev       = '0;
    fin_hs     = (v.exp_bytes == 0);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      step();
      Din_valid = 1'b0;
      if (cyc == 0) check_output({tag, "/first_valid"}, M_TVALID, v.exp_bytes > 0);
      if (fin_hs) begin
        check_output({tag, "/done_pulse"}, Done, 1);
        got_done = 1'b1;
        break;
      end
      if (Done) early_done++;
      if (perm_req) begin
        perms++;
        check_output({tag, "/perm_din_ready"}, Din_ready, 1);
        seed++;
        fill_state();
        Din       = st;
        Din_valid = 1'b1;
        blk       = 0;
      end
      if (M_TVALID) begin
        if (stall) check_output({tag, "/stall_stable"}, {M_TLAST, M_TDATA}, prev);
        M_TREADY = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (M_TREADY) begin
          for (int i = 0; i < B; i++)
            expw[8*i +: 8] = (emitted + i < v.exp_bytes) ? model_byte(st, blk + i) : 8'h00;
          check_output({tag, "/beat_data"}, M_TDATA, expw);
          check_output({tag, "/beat_last"}, M_TLAST, emitted + B >= v.exp_bytes);
          fin_hs  = (emitted + B >= v.exp_bytes);
          emitted += B;
          blk     += B;
          beats++;
        end
        stall = !M_TREADY;
        prev  = {M_TLAST, M_TDATA};
      end else begin
        stall = 1'b0;
      end
    end
    exp_beats = (v.exp_bytes + B - 1) / B;
    check_output({tag, "/beat_count"}, beats, exp_beats);
    check_output({tag, "/perm_count"}, perms, v.exp_perms);
    check_output({tag, "/got_done"}, got_done, 1);
    check_output({tag, "/early_done"}, early_done, 0);
    M_TREADY = 1'b1;
    step();
    check_output({tag, "/done_one_cycle"}, Done, 0);
    check_output({tag, "/idle_valid"}, M_TVALID, 0);
    check_output({tag, "/idle_ready"}, Din_ready, 1);
  endtask

  initial begin
    // mode, out_len, random ready, expected bytes, expected permutation requests
    vecs[0]  = '{3'd1, 16'd5,   1'b0, 32,  0};
    vecs[1]  = '{3'd0, 16'd5,   1'b0, 28,  0};
    vecs[2]  = '{3'd2, 16'd0,   1'b0, 48,  0};
    vecs[3]  = '{3'd3, 16'd9,   1'b0, 64,  0};
    vecs[4]  = '{3'd6, 16'd0,   1'b0, 32,  0};
    vecs[5]  = '{3'd7, 16'd77,  1'b0, 32,  0};
    vecs[6]  = '{3'd4, 16'd171, 1'b0, 171, 1};
    vecs[7]  = '{3'd5, 16'd272, 1'b0, 272, 1};
    vecs[8]  = '{3'd5, 16'd0,   1'b0, 0,   0};
    vecs[9]  = '{3'd4, 16'd1,   1'b0, 1,   0};
    vecs[10] = '{3'd3, 16'd0,   1'b1, 64,  0};
    vecs[11] = '{3'd4, 16'd169, 1'b1, 169, 1};

    ARESET    = 1'b1;
    Din       = '0;
    Din_valid = 1'b0;
    TUSER     = 3'd0;
    out_len   = 16'd0;
    M_TREADY  = 1'b0;
    repeat (3) step();
    check_output("rst_din_ready", Din_ready, 0);
    check_output("rst_tvalid", M_TVALID, 0);
    check_output("rst_perm_req", perm_req, 0);
    check_output("rst_tlast", M_TLAST, 0);
    check_output("rst_done", Done, 0);
    check_output("rst_tdata", M_TDATA, 0);
    ARESET = 1'b0;

    for (int k = 0; k < 12; k++) run_stream(vecs[k], $sformatf("vec%0d", k));

    // Abort a SHA3-384 stream after five accepted beats.
    apply_stimulus(3'd2, 16'd0);
    M_TREADY = 1'b1;
    repeat (6) begin
      step();
      Din_valid = 1'b0;
    end
    check_output("abort_pre_valid", M_TVALID, 1);
    ARESET = 1'b1;
    step();
    check_output("abort_tvalid", M_TVALID, 0);
    check_output("abort_din_ready", Din_ready, 0);
    check_output("abort_tlast", M_TLAST, 0);
    check_output("abort_tdata", M_TDATA, 0);
    check_output("abort_done", Done, 0);
    ARESET = 1'b0;
    step();
    check_output("abort_idle_ready", Din_ready, 1);
    check_output("abort_idle_valid", M_TVALID, 0);
    check_output("abort_no_done", Done, 0);
    run_stream(vecs[0], "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
